ovi_vec_issue_queue: RTL

Upstream neighbour of the OVI bridge: buffers vector instructions from the scalar core's decode stage in a small in-order FIFO and presents them one at a time on the bridge's core-issue bus. It also executes vsetvli/vsetivli/vsetvl locally. The resulting vl/sew state is stamped onto every later vector instruction at enqueue time, so the bridge sees each instruction with the vl/sew in force at that point in program order.

---
 rtl/ovi_vec_issue_queue_if.sv | 39 +++
 rtl/ovi_vec_issue_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ovi_vec_issue_queue_if.sv
// ovi_vec_issue_queue_if: decode-side and issue-side signals of the vector
// issue queue. The decode stage (and the bridge halt) is the master; the
// queue itself is the slave.
interface ovi_vec_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int VL_W  = 15
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // decode side
  logic              dec_valid;
  logic [31:0]       dec_instr;
  logic [63:0]       dec_rs1;
  logic [63:0]       dec_rs2;
  logic              dec_ready;
  logic              dec_flush;
  // issue side (towards the bridge)
  logic              issue_valid;
  logic [31:0]       issue_instr;
  logic [VL_W-1:0]   issue_vl;
  logic [2:0]        issue_sew;
  logic              issue_halt;
  // architectural vector state and occupancy
  logic [VL_W-1:0]   vset_vl;
  logic              vill;
  logic [CNT_W-1:0]  count;

  modport master (
    output dec_valid, dec_instr, dec_rs1, dec_rs2, dec_flush, issue_halt,
    input  dec_ready, issue_valid, issue_instr, issue_vl, issue_sew,
           vset_vl, vill, count
  );

  modport slave (
    input  dec_valid, dec_instr, dec_rs1, dec_rs2, dec_flush, issue_halt,
    output dec_ready, issue_valid, issue_instr, issue_vl, issue_sew,
           vset_vl, vill, count
  );
endinterface

// File: rtl/ovi_vec_issue_queue.sv
// ovi_vec_issue_queue: in-order FIFO of vector instructions between the scalar
// decode stage and the OVI bridge. vsetvli/vsetivli/vsetvl are executed here
// and never queued; every queued instruction is stamped with the vl/sew in
// force when it was enqueued.
// Optional feature: define OVI_VQ_BYPASS_EN to let an instruction arriving at
// an empty queue appear on the issue bus in the same cycle (0-cycle latency).
module ovi_vec_issue_queue #(
  parameter int DEPTH = 4,
  parameter int VLEN  = 512,
  parameter int VL_W  = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ovi_vec_issue_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [63:0] VLEN_64 = 64'(VLEN);

  // architectural vector state
  logic [VL_W-1:0]  vl_reg;
  logic [2:0]       sew_reg;
  logic             vill_reg;

  // FIFO state
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [31:0]      instr_mem [DEPTH];
  logic [VL_W-1:0]  vl_mem    [DEPTH];
  logic [2:0]       sew_mem   [DEPTH];

  // decode
  logic [31:0]      instr;
  logic             vset_form;
  logic             is_vsetvli;
  logic             is_vsetivli;
  logic             is_vsetvl;
  logic             is_vset;
  logic [10:0]      vtype;
  logic [63:0]      avl;
  logic [4:0]       rs1_field;
  logic [4:0]       rd_field;

  // new vector state computed from a vset*
  logic [2:0]       vsew;
  logic             vtype_bad;
  logic [63:0]      vlmax;
  logic [VL_W-1:0]  vl_next;
  logic [2:0]       sew_next;
  logic             vill_next;

  // FIFO control
  logic             full;
  logic             empty;
  logic             bypass_hit;
  logic             bypass_take;
  logic             push;
  logic             pop;

  assign instr     = bus.dec_instr;
  assign rs1_field = instr[19:15];
  assign rd_field  = instr[11:7];

  // Recognise the three vset* forms on the OP-V opcode with funct3=111.
  always_comb begin
    vset_form   = (instr[6:0] == 7'b1010111) && (instr[14:12] == 3'b111);
    is_vsetvli  = vset_form && !instr[31];
    is_vsetivli = vset_form && (instr[31:30] == 2'b11);
    is_vsetvl   = vset_form && (instr[31:25] == 7'b1000000);
    is_vset     = is_vsetvli || is_vsetivli || is_vsetvl;
  end

  // Select vtype and AVL sources according to the vset* form.
  always_comb begin
    vtype = bus.dec_rs2[10:0];
    avl   = bus.dec_rs1;
    if (is_vsetvli) begin
      vtype = instr[30:20];
    end else if (is_vsetivli) begin
      vtype = {1'b0, instr[29:20]};
      avl   = {59'd0, instr[19:15]};
    end
  end

  // Compute the vl/sew/vill that a vset* would establish; vlmul is ignored.
  always_comb begin
    vsew      = vtype[5:3];
    vtype_bad = vsew[2] || (vtype[7:6] != 2'b00);
    vlmax     = (VLEN_64 >> 3) >> vsew[1:0];
    vl_next   = vl_reg;
    sew_next  = vsew;
    vill_next = 1'b0;
    if (vtype_bad) begin
      vl_next   = '0;
      sew_next  = 3'd0;
      vill_next = 1'b1;
    end else if (!is_vsetivli && (rs1_field == 5'd0)) begin
      // rs1=x0: rd!=x0 requests VLMAX, rd=x0 keeps the current vl
      if (rd_field != 5'd0) begin
        vl_next = vlmax[VL_W-1:0];
      end
    end else if (avl < vlmax) begin
      vl_next = avl[VL_W-1:0];
    end else begin
      vl_next = vlmax[VL_W-1:0];
    end
  end

  // Push/pop qualification; a pop never frees a slot for a same-cycle push.
  always_comb begin
    full  = (count_reg == CNT_W'(DEPTH));
    empty = (count_reg == '0);
`ifdef OVI_VQ_BYPASS_EN
    bypass_hit = bus.dec_valid && !is_vset && empty && !bus.dec_flush;
`else
    bypass_hit = 1'b0;
`endif
    bypass_take = bypass_hit && !bus.issue_halt;
    push = bus.dec_valid && !is_vset && !full && !bus.dec_flush && !bypass_take;
    pop  = !empty && !bus.issue_halt && !bus.dec_flush;
  end

  assign bus.dec_ready = is_vset || (!full && !bus.dec_flush);

  // Architectural vl/sew/vill, updated by any valid vset*, even under flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vl_reg   <= '0;
      sew_reg  <= 3'd0;
      vill_reg <= 1'b1;
    end else if (bus.dec_valid && is_vset) begin
      vl_reg   <= vl_next;
      sew_reg  <= sew_next;
      vill_reg <= vill_next;
    end
  end

  // Pointers and occupancy; flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (bus.dec_flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  // One storage slot per entry, written at the tail with the current vl/sew.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    // Slot gi captures {instr, vl, sew} when it is the tail on a push.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        instr_mem[gi] <= '0;
        vl_mem[gi]    <= '0;
        sew_mem[gi]   <= 3'd0;
      end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        instr_mem[gi] <= instr;
        vl_mem[gi]    <= vl_reg;
        sew_mem[gi]   <= sew_reg;
      end
    end
  end

  // Head entry drives the issue bus (or the decode input when bypassing).
  always_comb begin
    bus.issue_valid = !empty;
    bus.issue_instr = instr_mem[rd_ptr_reg];
    bus.issue_vl    = vl_mem[rd_ptr_reg];
    bus.issue_sew   = sew_mem[rd_ptr_reg];
    if (bypass_hit) begin
      bus.issue_valid = 1'b1;
      bus.issue_instr = instr;
      bus.issue_vl    = vl_reg;
      bus.issue_sew   = sew_reg;
    end
  end

  assign bus.vset_vl = vl_reg;
  assign bus.vill    = vill_reg;
  assign bus.count   = count_reg;

  // Upper vtype/rs2 bits are architecturally ignored.
  logic unused_bits;
  assign unused_bits = ^{vtype[10:8], bus.dec_rs2[63:11]};

endmodule
